// File: rtl/stepper_ramp_driver.sv
// Stepper motor step/direction generator with trapezoidal speed ramp.
// A command is accepted while Waiting=1. The driver latches the direction,
// waits DIR_SETUP cycles, and then issues StepCount pulses. The period
// shrinks from StartPeriod toward MinPeriod during acceleration and grows back
// during deceleration. A limit switch in the direction of travel or Abort stops
// the move cleanly, without cutting a pulse short.
//
// Ports:
//   Clock100Mhz  - system clock (single domain)
//   Reset        - asynchronous active-high reset
//   StepWrite    - command strobe (sampled only while idle)
//   StepCount    - steps to issue
//   Direction    - 1 = toward end limit, 0 = toward start limit
//   StartPeriod  - first/last step period (cycles)
//   MinPeriod    - cruise period (cycles)
//   RampDelta    - period change per ramp step
//   LimitStart   - start-side limit switch (synchronised, active-high)
//   LimitEnd     - end-side limit switch (synchronised, active-high)
//   Abort        - controlled-stop request
//   StepOutput   - step pulse (registered)
//   DirOutput    - direction to driver (registered)
//   Waiting      - idle and ready for a command (registered)
//   Done         - one-cycle completion pulse (registered)
//   LimitHit     - last move ended by a limit switch
//   StepsDone    - rising edges issued in the current/last move
module stepper_ramp_driver #(
    parameter int CNT_W     = 20,
    parameter int PER_W     = 20,
    parameter int PULSE_W   = 200,
    parameter int DIR_SETUP = 100
) (
    input  logic             Clock100Mhz,
    input  logic             Reset,
    input  logic             StepWrite,
    input  logic [CNT_W-1:0] StepCount,
    input  logic             Direction,
    input  logic [PER_W-1:0] StartPeriod,
    input  logic [PER_W-1:0] MinPeriod,
    input  logic [PER_W-1:0] RampDelta,
    input  logic             LimitStart,
    input  logic             LimitEnd,
    input  logic             Abort,
    output logic             StepOutput,
    output logic             DirOutput,
    output logic             Waiting,
    output logic             Done,
    output logic             LimitHit,
    output logic [CNT_W-1:0] StepsDone
);

    localparam int TMR_W = (PER_W + 1 > 32) ? PER_W + 1 : 32;
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(DIR_SETUP - 1);
    localparam logic [TMR_W-1:0] MIN_PER    = TMR_W'(PULSE_W + 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, FINISH} state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [PER_W-1:0]   cur_per, cur_per_nxt;
    logic [CNT_W-1:0]   accel_cnt, accel_cnt_nxt;
    logic [CNT_W-1:0]   steps, steps_nxt;
    logic [CNT_W-1:0]   cmd_cnt, cmd_cnt_nxt;
    logic [PER_W-1:0]   cmd_start, cmd_start_nxt;
    logic [PER_W-1:0]   cmd_min, cmd_min_nxt;
    logic [PER_W-1:0]   cmd_delta, cmd_delta_nxt;
    logic               step_q, step_nxt;
    logic               dir_q, dir_nxt;
    logic               wait_q, wait_nxt;
    logic               done_q, done_nxt;
    logic               hit_q, hit_nxt;
    logic               lim_pend, lim_pend_nxt;
    logic               abort_pend, abort_pend_nxt;

    logic               lim_travel;
    logic               lim_accept;
    logic [PER_W-1:0]   start_sel;
    logic [TMR_W-1:0]   per_ext;
    logic [TMR_W-1:0]   per_eff;
    logic [TMR_W-1:0]   low_load;
    logic [PER_W:0]     per_diff;
    logic [PER_W:0]     per_sum;
    logic [PER_W-1:0]   per_down;
    logic [PER_W-1:0]   per_up;
    logic [CNT_W:0]     half_cnt;
    logic [CNT_W-1:0]   remaining;
    logic               in_decel;
    logic               in_accel;

    assign lim_travel = dir_q ? LimitEnd : LimitStart;
    assign lim_accept = Direction ? LimitEnd : LimitStart;
    assign start_sel  = (StartPeriod > MinPeriod) ? StartPeriod : MinPeriod;

    // Step period never drops below one cycle longer than the pulse, so the
    // output always has at least one low cycle between pulses.
    assign per_ext  = TMR_W'(cur_per);
    assign per_eff  = (per_ext > MIN_PER) ? per_ext : MIN_PER;
    assign low_load = per_eff - MIN_PER;

    // Ramp arithmetic carries one extra bit so underflow/overflow saturate.
    assign per_diff = {1'b0, cur_per} - {1'b0, cmd_delta};
    assign per_sum  = {1'b0, cur_per} + {1'b0, cmd_delta};
    assign per_down = (per_diff[PER_W] || (per_diff[PER_W-1:0] < cmd_min))
                      ? cmd_min : per_diff[PER_W-1:0];
    assign per_up   = (per_sum > {1'b0, cmd_start}) ? cmd_start : per_sum[PER_W-1:0];

    assign half_cnt  = ({1'b0, cmd_cnt} + (CNT_W+1)'(1)) >> 1;
    assign remaining = cmd_cnt - steps;
    assign in_decel  = (remaining <= accel_cnt);
    assign in_accel  = ({1'b0, steps} < half_cnt) && (cur_per > cmd_min);

    always_comb begin
        state_nxt      = state;
        timer_nxt      = timer;
        cur_per_nxt    = cur_per;
        accel_cnt_nxt  = accel_cnt;
        steps_nxt      = steps;
        cmd_cnt_nxt    = cmd_cnt;
        cmd_start_nxt  = cmd_start;
        cmd_min_nxt    = cmd_min;
        cmd_delta_nxt  = cmd_delta;
        step_nxt       = step_q;
        dir_nxt        = dir_q;
        wait_nxt       = wait_q;
        done_nxt       = 1'b0;
        hit_nxt        = hit_q;
        lim_pend_nxt   = lim_pend;
        abort_pend_nxt = abort_pend;

        unique case (state)
            IDLE: begin
                wait_nxt = 1'b1;
                if (StepWrite) begin
                    cmd_cnt_nxt   = StepCount;
                    cmd_start_nxt = StartPeriod;
                    cmd_min_nxt   = MinPeriod;
                    cmd_delta_nxt = RampDelta;
                    cur_per_nxt   = start_sel;
                    accel_cnt_nxt = '0;
                    steps_nxt     = '0;
                    dir_nxt       = Direction;
                    wait_nxt      = 1'b0;
                    hit_nxt       = 1'b0;
                    if (lim_accept) begin
                        hit_nxt   = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = FINISH;
                    end else if (StepCount == '0) begin
                        done_nxt  = 1'b1;
                        state_nxt = FINISH;
                    end else begin
                        timer_nxt = SETUP_LAST;
                        state_nxt = SETUP;
                    end
                end
            end

            SETUP: begin
                if (lim_travel || Abort) begin
                    hit_nxt   = lim_travel;
                    done_nxt  = 1'b1;
                    state_nxt = FINISH;
                end else if (timer == '0) begin
                    step_nxt       = 1'b1;
                    steps_nxt      = steps + CNT_W'(1);
                    timer_nxt      = PULSE_LAST;
                    lim_pend_nxt   = 1'b0;
                    abort_pend_nxt = 1'b0;
                    state_nxt      = HIGH;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            HIGH: begin
                // A stop seen mid-pulse is remembered and acted on once the
                // pulse has run its full width.
                lim_pend_nxt   = lim_pend | lim_travel;
                abort_pend_nxt = abort_pend | Abort;
                if (timer == '0) begin
                    step_nxt = 1'b0;
                    if (lim_pend || lim_travel || abort_pend || Abort) begin
                        hit_nxt   = lim_pend | lim_travel;
                        done_nxt  = 1'b1;
                        state_nxt = FINISH;
                    end else begin
                        timer_nxt = low_load;
                        state_nxt = LOW;
                        if (in_decel) begin
                            cur_per_nxt = per_up;
                        end else if (in_accel) begin
                            cur_per_nxt   = per_down;
                            accel_cnt_nxt = accel_cnt + CNT_W'(1);
                        end
                    end
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            LOW: begin
                if (lim_travel || Abort) begin
                    hit_nxt   = lim_travel;
                    done_nxt  = 1'b1;
                    state_nxt = FINISH;
                end else if (timer == '0) begin
                    if (steps == cmd_cnt) begin
                        done_nxt  = 1'b1;
                        state_nxt = FINISH;
                    end else begin
                        step_nxt       = 1'b1;
                        steps_nxt      = steps + CNT_W'(1);
                        timer_nxt      = PULSE_LAST;
                        lim_pend_nxt   = 1'b0;
                        abort_pend_nxt = 1'b0;
                        state_nxt      = HIGH;
                    end
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            FINISH: begin
                step_nxt  = 1'b0;
                wait_nxt  = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock100Mhz or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            timer      <= '0;
            cur_per    <= '0;
            accel_cnt  <= '0;
            steps      <= '0;
            cmd_cnt    <= '0;
            cmd_start  <= '0;
            cmd_min    <= '0;
            cmd_delta  <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            wait_q     <= 1'b1;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            lim_pend   <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            cur_per    <= cur_per_nxt;
            accel_cnt  <= accel_cnt_nxt;
            steps      <= steps_nxt;
            cmd_cnt    <= cmd_cnt_nxt;
            cmd_start  <= cmd_start_nxt;
            cmd_min    <= cmd_min_nxt;
            cmd_delta  <= cmd_delta_nxt;
            step_q     <= step_nxt;
            dir_q      <= dir_nxt;
            wait_q     <= wait_nxt;
            done_q     <= done_nxt;
            hit_q      <= hit_nxt;
            lim_pend   <= lim_pend_nxt;
            abort_pend <= abort_pend_nxt;
        end
    end

    assign StepOutput = step_q;
    assign DirOutput  = dir_q;
    assign Waiting    = wait_q;
    assign Done       = done_q;
    assign LimitHit   = hit_q;
    assign StepsDone  = steps;

endmodule

// File: tb/tb_stepper_ramp_driver.sv
// Scoreboard bench for stepper_ramp_driver (PULSE_W=2, DIR_SETUP=3).
// Stimulus pushes expected pulse/done events, with times relative to the
// command cycle, into a queue. A monitor pops and compares each event the DUT
// produces.
module tb_stepper_ramp_driver;

    localparam int CW = 16;
    localparam int PW = 16;

    typedef struct {
        int kind;   // 0 = pulse (reported at its falling edge), 1 = done
        int t;      // pulse: rise offset; done: done offset
        int a;      // pulse: high width;  done: StepsDone
        int b;      // pulse: StepsDone at rise; done: LimitHit
        int c;      // pulse: DirOutput at rise; done: 0
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr  = 1'b0;
    logic [CW-1:0] cnt = '0;
    logic          dir = 1'b0;
    logic [PW-1:0] sp  = '0;
    logic [PW-1:0] mp  = '0;
    logic [PW-1:0] rd  = '0;
    logic          ls  = 1'b0;
    logic          le  = 1'b0;
    logic          ab  = 1'b0;
    logic          so, dout, wt, dn, lh;
    logic [CW-1:0] sd;

    int  cyc   = 0;
    int  acc   = 0;
    int  tests = 0;
    int  fails = 0;
    ev_t exp_q[$];

    stepper_ramp_driver #(
        .CNT_W(CW), .PER_W(PW), .PULSE_W(2), .DIR_SETUP(3)
    ) dut (
        .Clock100Mhz(clk), .Reset(rst), .StepWrite(wr), .StepCount(cnt),
        .Direction(dir), .StartPeriod(sp), .MinPeriod(mp), .RampDelta(rd),
        .LimitStart(ls), .LimitEnd(le), .Abort(ab),
        .StepOutput(so), .DirOutput(dout), .Waiting(wt), .Done(dn),
        .LimitHit(lh), .StepsDone(sd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int k, input int t, input int a, input int b, input int c);
        ev_t e;
        e.kind = k; e.t = t; e.a = a; e.b = b; e.c = c;
        return e;
    endfunction

    task automatic exp_pulse(input int t, input int w, input int s, input int d);
        exp_q.push_back(mk(0, t, w, s, d));
    endtask

    task automatic exp_done(input int t, input int s, input int h);
        exp_q.push_back(mk(1, t, s, h, 0));
    endtask

    task automatic check_ev(input ev_t g);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_%s: got t=%0d a=%0d b=%0d c=%0d, required no event",
                     (g.kind == 0) ? "pulse" : "done", g.t, g.a, g.b, g.c);
        end else begin
            e = exp_q.pop_front();
            if (g.kind != e.kind || g.t != e.t || g.a != e.a || g.b != e.b || g.c != e.c) begin
                fails++;
                $display("FAIL event_%s: got kind=%0d t=%0d a=%0d b=%0d c=%0d, required kind=%0d t=%0d a=%0d b=%0d c=%0d",
                         (e.kind == 0) ? "pulse" : "done", g.kind, g.t, g.a, g.b, g.c,
                         e.kind, e.t, e.a, e.b, e.c);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: pulse events at the falling edge (carrying width), done events on Done.
    logic prev_so = 1'b0;
    int   hcnt = 0, rt = 0, rsd = 0, rdir = 0;
    always @(negedge clk) begin
        if (so && !prev_so) begin
            rt   = cyc - acc;
            hcnt = 1;
            rsd  = int'(sd);
            rdir = int'(dout);
        end else if (so) begin
            hcnt++;
        end else if (prev_so) begin
            check_ev(mk(0, rt, hcnt, rsd, rdir));
        end
        if (dn) check_ev(mk(1, cyc - acc, int'(sd), int'(lh), 0));
        prev_so = so;
    end

    // Command is presented in cycle N = acc; sampled at the following edge.
    // Returns at the negedge with offset t = 1. Inputs then go to junk values.
    task automatic issue(input int n, input logic d, input int s, input int m, input int delta);
        @(negedge clk);
        cnt = CW'(n); dir = d; sp = PW'(s); mp = PW'(m); rd = PW'(delta);
        wr  = 1'b1;
        acc = cyc;
        @(negedge clk);
        wr = 1'b0; cnt = '1; dir = ~d; sp = PW'(3); mp = PW'(2); rd = PW'(7);
    endtask

    task automatic wait_t(input int k);
        while (cyc - acc < k) @(negedge clk);
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && wt) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL drain_%s: got %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, checked before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_step", int'(so), 0);
        chk("rst_wait", int'(wt), 1);
        chk("rst_dir",  int'(dout), 0);
        chk("rst_done", int'(dn), 0);
        chk("rst_hit",  int'(lh), 0);
        chk("rst_sd",   int'(sd), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Constant period 5.
        for (int k = 0; k < 4; k++) exp_pulse(4 + 5 * k, 2, k + 1, 1);
        exp_done(24, 4, 0);
        issue(4, 1'b1, 5, 5, 0);
        chk("accept_wait", int'(wt), 0);
        chk("accept_dir",  int'(dout), 1);
        chk("accept_sd",   int'(sd), 0);
        drain("const");

        // Ramp 10,8,6,6,8,10.
        exp_pulse(4, 2, 1, 0);  exp_pulse(14, 2, 2, 0); exp_pulse(22, 2, 3, 0);
        exp_pulse(28, 2, 4, 0); exp_pulse(34, 2, 5, 0); exp_pulse(42, 2, 6, 0);
        exp_done(52, 6, 0);
        issue(6, 1'b0, 10, 6, 2);
        chk("ramp_dir", int'(dout), 0);
        drain("ramp");

        // End limit raised during third pulse; start limit toggling is ignored.
        exp_pulse(4, 2, 1, 1); exp_pulse(9, 2, 2, 1); exp_pulse(14, 2, 3, 1);
        exp_done(16, 3, 1);
        issue(10, 1'b1, 5, 5, 0);
        for (int k = 2; k <= 20; k++) begin
            wait_t(k);
            ls = k[0];
            if (k == 14) le = 1'b1;
        end
        drain("limit");
        chk("limit_hold_hit", int'(lh), 1);
        chk("limit_hold_sd", int'(sd), 3);
        le = 1'b0; ls = 1'b0;

        // Limit already active at acceptance: no steps.
        exp_done(1, 0, 1);
        ls = 1'b1;
        issue(5, 1'b0, 5, 5, 0);
        ls = 1'b0;
        drain("limit_accept");

        // Limit and Abort together during setup.
        exp_done(2, 0, 1);
        issue(5, 1'b1, 5, 5, 0);
        le = 1'b1; ab = 1'b1;
        wait_t(2);
        le = 1'b0; ab = 1'b0;
        drain("setup_stop");

        // Abort during LOW of step 2: LimitHit stays clear.
        exp_pulse(4, 2, 1, 1); exp_pulse(9, 2, 2, 1);
        exp_done(12, 2, 0);
        issue(8, 1'b1, 5, 5, 0);
        wait_t(11);
        ab = 1'b1;
        wait_t(12);
        ab = 1'b0;
        drain("abort");

        // StepCount = 0.
        exp_done(1, 0, 0);
        issue(0, 1'b1, 5, 5, 0);
        chk("zero_wait_n1", int'(wt), 0);
        chk("zero_hit_clr", int'(lh), 0);
        wait_t(2);
        chk("zero_wait_n2", int'(wt), 1);
        drain("zero");

        // StepWrite while busy is ignored.
        exp_pulse(4, 2, 1, 1); exp_pulse(9, 2, 2, 1); exp_pulse(14, 2, 3, 1);
        exp_done(19, 3, 0);
        issue(3, 1'b1, 5, 5, 0);
        wait_t(6);
        wr = 1'b1; cnt = CW'(9); dir = 1'b0;
        wait_t(7);
        wr = 1'b0;
        drain("busy");

        // Async reset mid-pulse truncates it to one sampled high cycle.
        exp_pulse(4, 1, 1, 1);
        issue(4, 1'b1, 5, 5, 0);
        wait_t(4);
        #2 rst = 1'b1;
        #1;
        chk("arst_step", int'(so), 0);
        chk("arst_wait", int'(wt), 1);
        chk("arst_dir",  int'(dout), 0);
        chk("arst_sd",   int'(sd), 0);
        chk("arst_done", int'(dn), 0);
        chk("arst_hit",  int'(lh), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain("arst");
        exp_pulse(4, 2, 1, 0); exp_pulse(9, 2, 2, 0);
        exp_done(14, 2, 0);
        issue(2, 1'b0, 5, 5, 0);
        drain("post_rst");

        // Period clamp to PULSE_W+1 = 3.
        exp_pulse(4, 2, 1, 1); exp_pulse(7, 2, 2, 1); exp_pulse(10, 2, 3, 1);
        exp_done(13, 3, 0);
        issue(3, 1'b1, 1, 1, 0);
        drain("clamp");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
